word_unstacker: RTL and testbench

WORD_UNSTACKER -- requirements
Module: word_unstacker

---
 rtl/word_unstacker.sv | 69 ++++++
 tb/tb_word_unstacker.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/word_unstacker.sv
// Splits each accepted 128-bit block into four 32-bit words, most significant word first.
// A new block can load on the same edge the final word leaves, so the output can carry one word every cycle.
module word_unstacker (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         enable_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [127:0] block_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [31:0]  word_o,
  output logic         last_o
);

  logic [127:0] r_data;
  logic [1:0]   r_cnt;
  logic         r_full;

  logic         w_active;
  logic         w_at_last;
  logic         w_in_hs;
  logic         w_out_hs;

  assign w_active  = enable_i & ~clr_i;
  assign w_at_last = (r_cnt == 2'd3);
  assign ready_o   = w_active & (~r_full | (ready_i & w_at_last));
  assign valid_o   = w_active & r_full;
  assign last_o    = valid_o & w_at_last;
  assign w_in_hs   = valid_i & ready_o;
  assign w_out_hs  = valid_o & ready_i;

  // The selected slice is visible even when valid_o is low.
  always_comb begin
    word_o = r_data[127:96];
    case (r_cnt)
      2'd0: word_o = r_data[127:96];
      2'd1: word_o = r_data[95:64];
      2'd2: word_o = r_data[63:32];
      2'd3: word_o = r_data[31:0];
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_data <= '0;
      r_cnt  <= 2'd0;
      r_full <= 1'b0;
    end else if (clr_i) begin
      r_data <= '0;
      r_cnt  <= 2'd0;
      r_full <= 1'b0;
    end else if (w_in_hs) begin
      // Loading also covers the zero-bubble case where the last word leaves on this edge.
      r_data <= block_i;
      r_cnt  <= 2'd0;
      r_full <= 1'b1;
    end else if (w_out_hs) begin
      if (w_at_last) begin
        r_cnt  <= 2'd0;
        r_full <= 1'b0;
      end else begin
        r_cnt  <= r_cnt + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_word_unstacker.sv
// Bench for word_unstacker: a remaining-words model checked every cycle, plus directed literal checks.
module tb_word_unstacker;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         clr_i = 1'b0;
  logic         enable_i = 1'b0;
  logic         valid_i = 1'b0;
  logic         ready_i = 1'b0;
  logic [127:0] block_i = '0;
  logic         ready_o;
  logic         valid_o;
  logic [31:0]  word_o;
  logic         last_o;

  int total = 0;
  int bad = 0;

  localparam logic [127:0] BLK_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] BLK_B = 128'hDEADBEEF_01234567_89ABCDEF_F00DCAFE;
  localparam logic [127:0] BLK_C = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] BLK_D = 128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3;
  localparam logic [127:0] BLK_E = 128'h0F0F0F0F_F0F0F0F0_55555555_AAAAAAAA;

  word_unstacker dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (clr_i),
    .enable_i(enable_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .block_i (block_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .word_o  (word_o),
    .last_o  (last_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the block held and how many of its words are still owed downstream.
  logic [127:0] m_blk = '0;
  int           m_rem = 0;

  function automatic logic [31:0] m_word();
    int idx;
    idx = (m_rem == 0) ? 0 : 4 - m_rem;
    return m_blk[127 - 32*idx -: 32];
  endfunction

  function automatic logic m_ready();
    return enable_i & ~clr_i & ((m_rem == 0) | (ready_i & (m_rem == 1)));
  endfunction

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_blk = '0;
      m_rem = 0;
    end else if (clr_i) begin
      m_blk = '0;
      m_rem = 0;
    end else if (enable_i) begin
      if (valid_i && m_ready()) begin
        m_blk = block_i;
        m_rem = 4;
      end else if (m_rem != 0 && ready_i) begin
        m_rem = m_rem - 1;
      end
    end
  end

  always @(negedge clk_i) begin
    logic ev;
    ev = enable_i & ~clr_i & (m_rem != 0);
    chk("model_valid", {31'd0, valid_o}, {31'd0, ev});
    chk("model_ready", {31'd0, ready_o}, {31'd0, m_ready()});
    chk("model_last", {31'd0, last_o}, {31'd0, ev & (m_rem == 1)});
    chk("model_word", word_o, m_word());
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // Presents a block and waits (bounded) for the edge that accepts it; valid_i stays high.
  task automatic send(input logic [127:0] b, output int n);
    logic ok;
    ok = 1'b0;
    n = 0;
    valid_i = 1'b1;
    block_i = b;
    while (!ok && n < 50) begin
      @(negedge clk_i);
      ok = ready_o;
      n++;
      cyc();
    end
    chk("send_accept", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    int n;
    logic [31:0] wa [4];
    logic [31:0] wd [4];
    logic [31:0] got [$];
    bit bp [12];
    wa = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    wd = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
    bp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    // Reset state
    #12;
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_last", {31'd0, last_o}, 32'd0);
    chk("rst_word", word_o, 32'h0);
    chk("rst_ready_dis", {31'd0, ready_o}, 32'd0);
    enable_i = 1'b1;
    #1;
    chk("rst_ready_en", {31'd0, ready_o}, 32'd1);
    #2 rst_ni = 1'b1;
    cyc();

    // Single block, 4 consecutive words, last only on the final one
    ready_i = 1'b1;
    send(BLK_A, n);
    valid_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      chk("single_word", word_o, wa[k]);
      chk("single_valid", {31'd0, valid_o}, 32'd1);
      chk("single_last", {31'd0, last_o}, (k == 3) ? 32'd1 : 32'd0);
      cyc();
    end
    @(negedge clk_i);
    chk("single_after_valid", {31'd0, valid_o}, 32'd0);
    cyc();

    // Back-to-back blocks: B loads on the edge A's last word leaves
    send(BLK_A, n);
    send(BLK_B, n);
    chk("b2b_accept_cycles", n, 32'd4);
    valid_i = 1'b0;
    @(negedge clk_i);
    chk("b2b_b_word0", word_o, 32'hDEADBEEF);
    chk("b2b_b_valid", {31'd0, valid_o}, 32'd1);
    repeat (5) cyc();

    // Backpressure: words held while ready_i low, none skipped or repeated
    send(BLK_D, n);
    valid_i = 1'b0;
    for (int i = 0; i < 12; i++) begin
      ready_i = bp[i];
      @(negedge clk_i);
      if (valid_o && ready_i) got.push_back(word_o);
      cyc();
    end
    chk("bp_word_count", got.size(), 32'd4);
    for (int k = 0; k < 4 && k < got.size(); k++) chk("bp_word_seq", got[k], wd[k]);
    ready_i = 1'b1;

    // Enable low for 3 cycles after word 1 has gone
    send(BLK_A, n);
    valid_i = 1'b0;
    repeat (2) cyc();
    enable_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("en_off_valid", {31'd0, valid_o}, 32'd0);
      chk("en_off_ready", {31'd0, ready_o}, 32'd0);
      chk("en_off_last", {31'd0, last_o}, 32'd0);
      cyc();
    end
    enable_i = 1'b1;
    @(negedge clk_i);
    chk("en_resume_word", word_o, 32'h8899AABB);
    chk("en_resume_valid", {31'd0, valid_o}, 32'd1);
    repeat (3) cyc();

    // Clear at counter 2 discards the block
    send(BLK_B, n);
    valid_i = 1'b0;
    repeat (2) cyc();
    clr_i = 1'b1;
    @(negedge clk_i);
    chk("clr_now_valid", {31'd0, valid_o}, 32'd0);
    chk("clr_now_ready", {31'd0, ready_o}, 32'd0);
    cyc();
    clr_i = 1'b0;
    @(negedge clk_i);
    chk("clr_after_valid", {31'd0, valid_o}, 32'd0);
    chk("clr_after_word", word_o, 32'h0);
    chk("clr_after_ready", {31'd0, ready_o}, 32'd1);
    cyc();
    send(BLK_C, n);
    valid_i = 1'b0;
    @(negedge clk_i);
    chk("clr_new_word0", word_o, 32'h11111111);
    repeat (4) cyc();

    // Asynchronous reset mid-block, between clock edges
    send(BLK_E, n);
    valid_i = 1'b0;
    cyc();
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_valid", {31'd0, valid_o}, 32'd0);
    chk("arst_last", {31'd0, last_o}, 32'd0);
    chk("arst_word", word_o, 32'h0);
    chk("arst_ready", {31'd0, ready_o}, 32'd1);
    cyc();
    #2 rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("arst_release_valid", {31'd0, valid_o}, 32'd0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
